// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the bit-serial arithmetic cells.
// Holds the control-state encoding that the serial adder FSM uses.
package arith_pkg;

   // Control states of the bit-serial datapath; the encoding 2'd3 is never
   // entered and the FSM treats it as a request to return to idle.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : arith_pkg

// File: rtl/full_adder.sv
// Single-bit full adder built from two half-adder stages and an OR gate.
// This is the addition dual of the half-subtractor cell: the first stage
// adds a and b, the second stage folds in the incoming carry, and either
// stage producing a carry yields the carry-out.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic ha1Sum;
   logic ha1Carry;
   logic ha2Carry;

   // First half adder combines the two operand bits, the second adds the
   // carry-in to that partial sum; the two carries can never both be set.
   always_comb begin
      ha1Sum   = a ^ b;
      ha1Carry = a & b;
      s        = ha1Sum ^ ci;
      ha2Carry = ha1Sum & ci;
      co       = ha1Carry | ha2Carry;
   end

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with valid/ready handshakes on both sides.
// Operands are latched into shift registers and added LSB-first through a
// single full-adder cell, one bit per clock, with the carry kept in a flop.
// The carry into the MSB is captured one bit early so that signed overflow
// can be formed from it and the final carry-out on the last bit.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   import arith_pkg::*;

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e             state_q;
   logic [WIDTH-1:0]   aSh_q;
   logic [WIDTH-1:0]   bSh_q;
   logic [WIDTH-1:0]   sumSh_q;
   logic               carry_q;
   logic               cmsb_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               outValid_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               ovf_q;

   logic [WIDTH-1:0]   aSh_d;
   logic [WIDTH-1:0]   bSh_d;
   logic [WIDTH-1:0]   sumSh_d;
   logic [CNT_W-1:0]   cnt_d;
   logic               lastBit;
   logic               msbCarryBit;

   logic               faSum;
   logic               faCarry;

   full_adder uFullAdder (
      .a  (aSh_q[0]),
      .b  (bSh_q[0]),
      .ci (carry_q),
      .s  (faSum),
      .co (faCarry)
   );

   // Next values of the shifting datapath for one BUSY step: operands move
   // right, the new sum bit enters at the top, and the bit counter advances.
   always_comb begin
      aSh_d       = aSh_q >> 1;
      bSh_d       = bSh_q >> 1;
      sumSh_d     = {faSum, sumSh_q[WIDTH-1:1]};
      cnt_d       = cnt_q + CNT_W'(1);
      lastBit     = (cnt_q == CNT_W'(WIDTH - 1));
      msbCarryBit = (cnt_q == CNT_W'(WIDTH - 2));
   end

   // Control FSM together with every datapath and output register; the
   // outputs only change on the last BUSY bit and when the result is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         aSh_q      <= '0;
         bSh_q      <= '0;
         sumSh_q    <= '0;
         carry_q    <= 1'b0;
         cmsb_q     <= 1'b0;
         cnt_q      <= '0;
         outValid_q <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  aSh_q   <= a;
                  bSh_q   <= b;
                  carry_q <= cin;
                  sumSh_q <= '0;
                  cmsb_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               aSh_q   <= aSh_d;
               bSh_q   <= bSh_d;
               sumSh_q <= sumSh_d;
               carry_q <= faCarry;
               cnt_q   <= cnt_d;
               if (msbCarryBit) begin
                  cmsb_q <= faCarry;
               end
               if (lastBit) begin
                  sum_q      <= sumSh_d;
                  cout_q     <= faCarry;
                  ovf_q      <= cmsb_q ^ faCarry;
                  outValid_q <= 1'b1;
                  state_q    <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = outValid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for the 8-bit serial adder.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a         = '0;
   logic [WIDTH-1:0] b         = '0;
   logic             cin       = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int nVectors     = 0;
   int nMiscompares = 0;
   int cycle        = 0;
   int acceptCycle  = 0;
   int prevAccept   = 0;
   int waitCount    = 0;

   logic [WIDTH-1:0] aV;
   logic [WIDTH-1:0] bV;
   logic             cV;
   logic [WIDTH:0]   fullSum;
   logic             expOvf;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Free-running clock and a rising-edge counter used for latency checks.
   always #5 clk = ~clk;

   // Counts rising edges so falling-edge samples can tell elapsed cycles.
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nVectors++;
      assert (observed === expected) else begin
         nMiscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents operands for one accept, then scrambles them while BUSY.
   task automatic applyStimulus(input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn,
                                input logic cIn);
      @(negedge clk);
      a = aIn; b = bIn; cin = cIn; in_valid = 1'b1;
      checkOutput("inReadyBeforeAccept", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid    = 1'b0;
      acceptCycle = cycle;
      a = ~aIn; b = ~bIn; cin = ~cIn;
      checkOutput("inReadyBusy", 32'(in_ready), 32'd0);
   endtask

   task automatic waitResult();
      waitCount = 0;
      while (out_valid !== 1'b1 && waitCount < 20) begin
         @(negedge clk);
         waitCount++;
      end
      checkOutput("outValidTimeout", 32'(out_valid), 32'd1);
   endtask

   task automatic checkResult(input string tag, input logic [WIDTH-1:0] expSum,
                              input logic expCout, input logic expOvfIn);
      checkOutput({tag, ".sum"}, 32'(sum), 32'(expSum));
      checkOutput({tag, ".cout"}, 32'(cout), 32'(expCout));
      checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expOvfIn));
      checkOutput({tag, ".latency"}, 32'(cycle - acceptCycle), 32'd8);
   endtask

   task automatic releaseResult();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("outValidAfterTake", 32'(out_valid), 32'd0);
      checkOutput("inReadyAfterTake", 32'(in_ready), 32'd1);
   endtask

   task automatic doOp(input string tag, input logic [WIDTH-1:0] aIn,
                       input logic [WIDTH-1:0] bIn, input logic cIn,
                       input logic [WIDTH-1:0] expSum, input logic expCout,
                       input logic expOvfIn);
      applyStimulus(aIn, bIn, cIn);
      waitResult();
      checkResult(tag, expSum, expCout, expOvfIn);
      releaseResult();
   endtask

   // Directed sequence: reset, corner additions, stall, mid-op reset, streaming.
   initial begin
      #2;
      checkOutput("resetInReady", 32'(in_ready), 32'd1);
      checkOutput("resetOutValid", 32'(out_valid), 32'd0);
      checkOutput("resetSum", 32'(sum), 32'd0);
      checkOutput("resetCoutOvf", {30'd0, cout, ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      doOp("basic",   8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
      doOp("wrap",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      doOp("posOvf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      doOp("negOvf",  8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);
      doOp("cinOnly", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

      // Result held while the consumer stalls; new operands offered meanwhile.
      applyStimulus(8'hC3, 8'h25, 1'b0);
      waitResult();
      checkResult("stall", 8'hE8, 1'b0, 1'b0);
      a = 8'hAA; b = 8'h11; cin = 1'b1; in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checkOutput("stallOutValid", 32'(out_valid), 32'd1);
         checkOutput("stallSum", 32'(sum), 32'hE8);
         checkOutput("stallInReady", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      releaseResult();
      doOp("afterStall", 8'h55, 8'h22, 1'b0, 8'h77, 1'b0, 1'b0);

      // Leave nonzero outputs behind, then reset in the middle of an op.
      doOp("preReset", 8'h80, 8'h81, 1'b0, 8'h01, 1'b1, 1'b1);
      applyStimulus(8'hF0, 8'h0F, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midResetOutValid", 32'(out_valid), 32'd0);
      checkOutput("midResetInReady", 32'(in_ready), 32'd1);
      checkOutput("midResetSum", 32'(sum), 32'd0);
      checkOutput("midResetCout", 32'(cout), 32'd0);
      checkOutput("midResetOvf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      doOp("afterReset", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

      // Streaming with out_ready held high: IDLE + 8 BUSY + 1 DONE cycles
      // separate consecutive accepts.
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         aV = WIDTH'($urandom);
         bV = WIDTH'($urandom);
         cV = 1'($urandom);
         fullSum = {1'b0, aV} + {1'b0, bV} + {{WIDTH{1'b0}}, cV};
         expOvf  = (aV[WIDTH-1] == bV[WIDTH-1]) && (fullSum[WIDTH-1] != aV[WIDTH-1]);
         a = aV; b = bV; cin = cV; in_valid = 1'b1;
         waitCount = 0;
         while (in_ready !== 1'b1 && waitCount < 20) begin
            @(negedge clk);
            waitCount++;
         end
         checkOutput("b2bInReady", 32'(in_ready), 32'd1);
         @(negedge clk);
         acceptCycle = cycle;
         if (i > 0) begin
            checkOutput("b2bSpacing", 32'(acceptCycle - prevAccept), 32'(WIDTH + 2));
         end
         prevAccept = acceptCycle;
         waitResult();
         checkOutput("b2bResult", {22'd0, cout, ovf, sum}, {22'd0, fullSum[WIDTH], expOvf, fullSum[WIDTH-1:0]});
         checkOutput("b2bLatency", 32'(cycle - acceptCycle), 32'd8);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule : tb_serial_adder
